// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the ID/EX operand stage.
//   DATA_W / REG_AW : default datapath and register-number widths
//   ZERO_REG        : the hard-wired zero register (never forwarded)
//   fwd_sel_e       : which source a forwarded operand came from
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_MM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: resolves one source operand against the EX and MEM
// destinations. EX beats MEM; a load in EX is not forwardable (its data is
// not ready yet, that case is covered by the load-use bubble).
//   src_rn_i / rf_val_i          : source register number and regfile value
//   ex_wreg_i/ex_m2reg_i/ex_rn_i/ex_alu_i : instruction currently in EX
//   mm_wreg_i/mm_rn_i/mm_data_i  : instruction currently in MEM
//   fwd_val_o                    : resolved operand value
//   fwd_sel_o                    : source that supplied it
module fwd_select
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] src_rn_i,
  input  logic [DW-1:0] rf_val_i,
  input  logic          ex_wreg_i,
  input  logic          ex_m2reg_i,
  input  logic [AW-1:0] ex_rn_i,
  input  logic [DW-1:0] ex_alu_i,
  input  logic          mm_wreg_i,
  input  logic [AW-1:0] mm_rn_i,
  input  logic [DW-1:0] mm_data_i,
  output logic [DW-1:0] fwd_val_o,
  output fwd_sel_e      fwd_sel_o
);

  // Forward-source priority mux: EX result, then MEM writeback, then regfile.
  always_comb begin
    fwd_val_o = rf_val_i;
    fwd_sel_o = FWD_RF;
    if (src_rn_i == AW'(ZERO_REG)) begin
      fwd_val_o = rf_val_i;
      fwd_sel_o = FWD_RF;
    end else if (ex_wreg_i && !ex_m2reg_i && (ex_rn_i == src_rn_i)) begin
      fwd_val_o = ex_alu_i;
      fwd_sel_o = FWD_EX;
    end else if (mm_wreg_i && (mm_rn_i == src_rn_i)) begin
      fwd_val_o = mm_data_i;
      fwd_sel_o = FWD_MM;
    end else begin
      fwd_val_o = rf_val_i;
      fwd_sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: builds ALU operands A/B and store data from the ID
// stage, with EX/MEM forwarding, immediate extension and shift-amount
// selection, and registers them as the ID/EX pipeline boundary.
//   clk, rst            : clock, synchronous active-high reset
//   id_*                : decoded instruction fields and regfile read data
//   ex_* (inputs)       : instruction currently in EX (forward source)
//   mm_*                : instruction currently in MEM (forward source)
//   stall, flush        : external hold / kill of the ID instruction
//   lu_stall            : combinational load-use hazard to the front end
//   ex_a/ex_b/ex_st     : registered ALU operands and store data
//   ex_valid            : registered instruction valid
module alu_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int IMM_W   = 16,
  parameter int REG_AW  = mips_pkg::REG_AW,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_qa,
  input  logic [DATA_W-1:0]  id_qb,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic [IMM_W-1:0]   id_imm,
  input  logic [SHAMT_W-1:0] id_shamt,
  input  logic               id_aluimm,
  input  logic               id_sext,
  input  logic               id_shift,
  input  logic               ex_wreg,
  input  logic               ex_m2reg,
  input  logic [REG_AW-1:0]  ex_rn,
  input  logic [DATA_W-1:0]  ex_alu,
  input  logic               mm_wreg,
  input  logic [REG_AW-1:0]  mm_rn,
  input  logic [DATA_W-1:0]  mm_data,
  input  logic               stall,
  input  logic               flush,
  output logic               lu_stall,
  output logic [DATA_W-1:0]  ex_a,
  output logic [DATA_W-1:0]  ex_b,
  output logic [DATA_W-1:0]  ex_st,
  output logic               ex_valid
);

  logic [DATA_W-1:0] fa_s, fb_s, imm_x_s, shamt_x_s;
  fwd_sel_e          sel_a_s, sel_b_s;
  logic              unused_sel_s;
  logic [DATA_W-1:0] a_d, b_d, st_d;
  logic              valid_d;
  logic [DATA_W-1:0] a_q, b_q, st_q;
  logic              valid_q;

  fwd_select #(.DW(DATA_W), .AW(REG_AW)) u_fwd_rs (
    .src_rn_i  (id_rs),
    .rf_val_i  (id_qa),
    .ex_wreg_i (ex_wreg),
    .ex_m2reg_i(ex_m2reg),
    .ex_rn_i   (ex_rn),
    .ex_alu_i  (ex_alu),
    .mm_wreg_i (mm_wreg),
    .mm_rn_i   (mm_rn),
    .mm_data_i (mm_data),
    .fwd_val_o (fa_s),
    .fwd_sel_o (sel_a_s)
  );

  fwd_select #(.DW(DATA_W), .AW(REG_AW)) u_fwd_rt (
    .src_rn_i  (id_rt),
    .rf_val_i  (id_qb),
    .ex_wreg_i (ex_wreg),
    .ex_m2reg_i(ex_m2reg),
    .ex_rn_i   (ex_rn),
    .ex_alu_i  (ex_alu),
    .mm_wreg_i (mm_wreg),
    .mm_rn_i   (mm_rn),
    .mm_data_i (mm_data),
    .fwd_val_o (fb_s),
    .fwd_sel_o (sel_b_s)
  );

  // Select codes are kept for debug visibility; the datapath uses the values.
  assign unused_sel_s = ^{sel_a_s, sel_b_s};

  // A load in EX whose destination is read by ID cannot be forwarded yet.
  assign lu_stall = id_valid && ex_wreg && ex_m2reg && (ex_rn != REG_AW'(ZERO_REG)) &&
                    ((id_use_rs && (ex_rn == id_rs)) || (id_use_rt && (ex_rn == id_rt)));

  assign imm_x_s   = id_sext ? {{(DATA_W-IMM_W){id_imm[IMM_W-1]}}, id_imm}
                             : {{(DATA_W-IMM_W){1'b0}}, id_imm};
  assign shamt_x_s = {{(DATA_W-SHAMT_W){1'b0}}, id_shamt};

  // Next-state operand muxes; store data is always the forwarded rt value.
  always_comb begin
    a_d     = id_shift  ? shamt_x_s : fa_s;
    b_d     = id_aluimm ? imm_x_s   : fb_s;
    st_d    = fb_s;
    valid_d = id_valid;
  end

  // ID/EX boundary register: rst > stall > flush/load-use bubble > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      st_q    <= '0;
      valid_q <= 1'b0;
    end else if (stall) begin
      a_q     <= a_q;
      b_q     <= b_q;
      st_q    <= st_q;
      valid_q <= valid_q;
    end else if (flush || lu_stall) begin
      a_q     <= '0;
      b_q     <= '0;
      st_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      st_q    <= st_d;
      valid_q <= valid_d;
    end
  end

  assign ex_a     = a_q;
  assign ex_b     = b_q;
  assign ex_st    = st_q;
  assign ex_valid = valid_q;

endmodule
